fp_multiplier: RTL

Iterative IEEE-754 single-precision multiplier, the companion of the team's single-precision divider in the same FP datapath. Accepts two operands on a one-cycle `start` pulse and retires mantissa partial products over several cycles. Normalises, rounds and packs the result. Presents `output_z` with a one-cycle `done` pulse after a fixed latency, and holds `output_z` until the next accepted operation.

---
 rtl/fp_pkg.sv | 28 ++
 rtl/fp_classify.sv | 25 ++
 rtl/fp_multiplier.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared single-precision FP definitions for the multiplier/divider datapath.
package fp_pkg;

    localparam int unsigned FP_WIDTH    = 32;
    localparam int unsigned FP_EXP_W    = 8;
    localparam int unsigned FP_FRAC_W   = 23;
    localparam int unsigned FP_MANT_W   = 24;
    localparam int unsigned FP_EXP_BIAS = 127;

    localparam logic [FP_WIDTH-1:0] FP_QNAN    = 32'h7FC00000;
    localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = 8'hFF;

    // Operand classification flags, bit order nan/inf/zero (MSB to LSB)
    typedef struct packed {
        logic is_nan;
        logic is_inf;
        logic is_zero;
    } fp_class_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_MUL,
        ST_NORM,
        ST_ROUND
    } fp_state_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 single classifier; subnormals are reported as zero.
module fp_classify
    import fp_pkg::*;
(
    input  logic [FP_WIDTH-1:0]  operand,
    output logic                 is_nan,
    output logic                 is_inf,
    output logic                 is_zero,
    output logic [FP_MANT_W-1:0] mant
);

    logic [FP_EXP_W-1:0]  exp_f;
    logic [FP_FRAC_W-1:0] frac_f;
    logic                 unused_sign;

    assign unused_sign = operand[FP_WIDTH-1];
    assign exp_f       = operand[FP_WIDTH-2 -: FP_EXP_W];
    assign frac_f      = operand[FP_FRAC_W-1:0];

    assign is_nan  = (exp_f == FP_EXP_MAX) && (frac_f != '0);
    assign is_inf  = (exp_f == FP_EXP_MAX) && (frac_f == '0);
    assign is_zero = (exp_f == '0);
    assign mant    = is_zero ? '0 : {1'b1, frac_f};

endmodule

// File: rtl/fp_multiplier.sv
// Iterative IEEE-754 single multiplier (shift-add, BITS_PER_CYCLE bits per cycle).
// Define FPMUL_RNE_EN for round-to-nearest-even; otherwise results truncate.
module fp_multiplier
    import fp_pkg::*;
#(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [FP_WIDTH-1:0] input_a,
    input  logic [FP_WIDTH-1:0] input_b,
    output logic                busy,
    output logic                done,
    output logic [FP_WIDTH-1:0] output_z
);

    localparam int unsigned MUL_CYCLES = FP_MANT_W / BITS_PER_CYCLE;
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned PROD_W     = 2 * FP_MANT_W;
    localparam int unsigned SEXP_W     = 10;

    fp_state_t                   state_q, state_d;
    logic [FP_WIDTH-1:0]         a_q, a_d, b_q, b_d;
    fp_class_t                   cls_a_q, cls_a_d, cls_b_q, cls_b_d;
    logic                        sign_q, sign_d;
    logic signed [SEXP_W-1:0]    exp_q, exp_d;
    logic [PROD_W-1:0]           mcand_q, mcand_d;
    logic [FP_MANT_W-1:0]        mult_q, mult_d;
    logic [PROD_W-1:0]           acc_q, acc_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [FP_FRAC_W-1:0]        frac_q, frac_d;
    logic                        busy_d, done_d;
    logic [FP_WIDTH-1:0]         z_d;
    logic [PROD_W-1:0]           partial;

    logic                        a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
    logic [FP_MANT_W-1:0]        mant_a, mant_b;

    logic                        any_nan;
    logic [FP_FRAC_W-1:0]        frac_fin;
    logic signed [SEXP_W-1:0]    exp_fin;
    logic [FP_WIDTH-1:0]         result;

`ifdef FPMUL_RNE_EN
    logic                        guard_q, guard_d, sticky_q, sticky_d;
    logic                        round_up;
    logic [FP_MANT_W:0]          mant_rnd;
`else
    logic                        unused_low;
    assign unused_low = ^acc_q[FP_FRAC_W-1:0];
`endif

    fp_classify u_cls_a (
        .operand (a_q),
        .is_nan  (a_nan),
        .is_inf  (a_inf),
        .is_zero (a_zero),
        .mant    (mant_a)
    );

    fp_classify u_cls_b (
        .operand (b_q),
        .is_nan  (b_nan),
        .is_inf  (b_inf),
        .is_zero (b_zero),
        .mant    (mant_b)
    );

    // Round, range-check and special-case selection for the ROUND state
    always_comb begin
        any_nan = cls_a_q.is_nan | cls_b_q.is_nan
                | (cls_a_q.is_inf & cls_b_q.is_zero)
                | (cls_a_q.is_zero & cls_b_q.is_inf);
        frac_fin = frac_q;
        exp_fin  = exp_q;
`ifdef FPMUL_RNE_EN
        round_up = guard_q & (sticky_q | frac_q[0]);
        mant_rnd = {2'b01, frac_q} + 25'(round_up);
        if (mant_rnd[FP_MANT_W]) begin
            frac_fin = mant_rnd[FP_FRAC_W:1];
            exp_fin  = exp_q + 10'sd1;
        end else begin
            frac_fin = mant_rnd[FP_FRAC_W-1:0];
        end
`endif
        if (any_nan) begin
            result = FP_QNAN;
        end else if (cls_a_q.is_inf | cls_b_q.is_inf) begin
            result = {sign_q, FP_EXP_MAX, 23'b0};
        end else if (cls_a_q.is_zero | cls_b_q.is_zero) begin
            result = {sign_q, 31'b0};
        end else if (exp_fin >= 10'sd255) begin
            result = {sign_q, FP_EXP_MAX, 23'b0};
        end else if (exp_fin <= 10'sd0) begin
            result = {sign_q, 31'b0};
        end else begin
            result = {sign_q, exp_fin[FP_EXP_W-1:0], frac_fin};
        end
    end

    // Partial product for the multiplier bits retired this cycle
    always_comb begin
        partial = '0;
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            if (mult_q[i]) begin
                partial = partial + (mcand_q << i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        cls_a_d  = cls_a_q;
        cls_b_d  = cls_b_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mcand_d  = mcand_q;
        mult_d   = mult_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        frac_d   = frac_q;
        busy_d   = 1'b1;
        done_d   = 1'b0;
        z_d      = output_z;
`ifdef FPMUL_RNE_EN
        guard_d  = guard_q;
        sticky_d = sticky_q;
`endif
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    a_d     = input_a;
                    b_d     = input_b;
                    busy_d  = 1'b1;
                    state_d = ST_UNPACK;
                end
            end
            ST_UNPACK: begin
                cls_a_d = {a_nan, a_inf, a_zero};
                cls_b_d = {b_nan, b_inf, b_zero};
                sign_d  = a_q[FP_WIDTH-1] ^ b_q[FP_WIDTH-1];
                exp_d   = 10'(a_q[FP_WIDTH-2 -: FP_EXP_W])
                        + 10'(b_q[FP_WIDTH-2 -: FP_EXP_W])
                        - 10'(FP_EXP_BIAS);
                mcand_d = 48'(mant_a);
                mult_d  = mant_b;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = ST_MUL;
            end
            ST_MUL: begin
                acc_d   = acc_q + partial;
                mcand_d = mcand_q << BITS_PER_CYCLE;
                mult_d  = mult_q >> BITS_PER_CYCLE;
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == 5'(MUL_CYCLES - 1)) begin
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                if (acc_q[PROD_W-1]) begin
                    frac_d   = acc_q[46:24];
                    exp_d    = exp_q + 10'sd1;
`ifdef FPMUL_RNE_EN
                    guard_d  = acc_q[23];
                    sticky_d = |acc_q[22:0];
`endif
                end else begin
                    frac_d   = acc_q[45:23];
`ifdef FPMUL_RNE_EN
                    guard_d  = acc_q[22];
                    sticky_d = |acc_q[21:0];
`endif
                end
                state_d = ST_ROUND;
            end
            ST_ROUND: begin
                z_d     = result;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            cls_a_q  <= '0;
            cls_b_q  <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mcand_q  <= '0;
            mult_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            frac_q   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            output_z <= '0;
`ifdef FPMUL_RNE_EN
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cls_a_q  <= cls_a_d;
            cls_b_q  <= cls_b_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mcand_q  <= mcand_d;
            mult_q   <= mult_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            frac_q   <= frac_d;
            busy     <= busy_d;
            done     <= done_d;
            output_z <= z_d;
`ifdef FPMUL_RNE_EN
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
`endif
        end
    end

endmodule
